// File: rtl/dds_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// dds_sweep_ctrl
//   Frequency-sweep / hop sequencer for the DDS waveform generator. It steps
//   the tuning word linearly from start_word by step_word, holding each value
//   for dwell+1 cycles. It supports single-shot and continuous modes and uses
//   a start/busy/done handshake.
//
// Ports
//   clk_in      : single clock; all logic on its rising edge
//   rst_in      : asynchronous, active-high reset
//   start       : sweep request, sampled only while idle
//   abort       : terminate sweep immediately; priority over start and hold
//   hold        : freeze counters and outputs while running
//   mode_cont   : 0 = single-shot, 1 = continuous (restart at start_word)
//   start_word  : first tuning word of a pass
//   step_word   : signed increment per step (two's complement)
//   step_num    : number of steps; step_num+1 distinct words per pass
//   dwell       : each word is held dwell+1 cycles
//   pha_in      : phase offset forwarded to Pha_word at start
//   Fre_word    : registered tuning word to the DDS
//   Pha_word    : registered phase word to the DDS
//   busy        : high while a sweep is running
//   done        : one-cycle pulse at the end of a single-shot sweep
//   step_tick   : one-cycle pulse on every edge that loads a new Fre_word
// ----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int PHASE_WIDTH = 32,
    parameter int STEP_WIDTH  = 16,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   hold,
    input  logic                   mode_cont,
    input  logic [PHASE_WIDTH-1:0] start_word,
    input  logic [PHASE_WIDTH-1:0] step_word,
    input  logic [STEP_WIDTH-1:0]  step_num,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic [PHASE_WIDTH-1:0] pha_in,
    output logic [PHASE_WIDTH-1:0] Fre_word,
    output logic [PHASE_WIDTH-1:0] Pha_word,
    output logic                   busy,
    output logic                   done,
    output logic                   step_tick
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [STEP_WIDTH-1:0]  STEP_ONE  = STEP_WIDTH'(1);
    localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [PHASE_WIDTH-1:0]   fre_q, fre_d;
    logic [PHASE_WIDTH-1:0]   pha_q, pha_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     tick_q, tick_d;
    logic [STEP_WIDTH-1:0]    step_idx_q, step_idx_d;
    logic [DWELL_WIDTH-1:0]   dwell_cnt_q, dwell_cnt_d;

    // Sweep configuration captured at start so input changes mid-sweep are ignored.
    logic [PHASE_WIDTH-1:0]   start_l_q, start_l_d;
    logic [PHASE_WIDTH-1:0]   step_l_q, step_l_d;
    logic [STEP_WIDTH-1:0]    step_num_l_q, step_num_l_d;
    logic [DWELL_WIDTH-1:0]   dwell_l_q, dwell_l_d;
    logic                     cont_l_q, cont_l_d;

    always_comb begin
        state_d      = state_q;
        fre_d        = fre_q;
        pha_d        = pha_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tick_d       = 1'b0;
        step_idx_d   = step_idx_q;
        dwell_cnt_d  = dwell_cnt_q;
        start_l_d    = start_l_q;
        step_l_d     = step_l_q;
        step_num_l_d = step_num_l_q;
        dwell_l_d    = dwell_l_q;
        cont_l_d     = cont_l_q;

        if (abort) begin
            // Output words are deliberately left at their last value.
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        start_l_d    = start_word;
                        step_l_d     = step_word;
                        step_num_l_d = step_num;
                        dwell_l_d    = dwell;
                        cont_l_d     = mode_cont;
                        fre_d        = start_word;
                        pha_d        = pha_in;
                        step_idx_d   = '0;
                        dwell_cnt_d  = '0;
                        busy_d       = 1'b1;
                        tick_d       = 1'b1;
                        state_d      = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!hold) begin
                        if (dwell_cnt_q != dwell_l_q) begin
                            dwell_cnt_d = dwell_cnt_q + DWELL_ONE;
                        end else if (step_idx_q != step_num_l_q) begin
                            // Modular add: a sweep may wrap through zero.
                            fre_d       = fre_q + step_l_q;
                            step_idx_d  = step_idx_q + STEP_ONE;
                            dwell_cnt_d = '0;
                            tick_d      = 1'b1;
                        end else if (cont_l_q) begin
                            fre_d       = start_l_q;
                            step_idx_d  = '0;
                            dwell_cnt_d = '0;
                            tick_d      = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            fre_q        <= '0;
            pha_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tick_q       <= 1'b0;
            step_idx_q   <= '0;
            dwell_cnt_q  <= '0;
            start_l_q    <= '0;
            step_l_q     <= '0;
            step_num_l_q <= '0;
            dwell_l_q    <= '0;
            cont_l_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fre_q        <= fre_d;
            pha_q        <= pha_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tick_q       <= tick_d;
            step_idx_q   <= step_idx_d;
            dwell_cnt_q  <= dwell_cnt_d;
            start_l_q    <= start_l_d;
            step_l_q     <= step_l_d;
            step_num_l_q <= step_num_l_d;
            dwell_l_q    <= dwell_l_d;
            cont_l_q     <= cont_l_d;
        end
    end

    assign Fre_word  = fre_q;
    assign Pha_word  = pha_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign step_tick = tick_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Directed testbench for dds_sweep_ctrl: reset, single-shot sweep, wrap,
//   continuous sweep, hold, abort, and back-to-back start on the done cycle.
// ----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    localparam int PW = 32;
    localparam int SW = 16;
    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          start, abort, hold, mode_cont;
    logic [PW-1:0] start_word, step_word, pha_in;
    logic [SW-1:0] step_num;
    logic [DW-1:0] dwell;
    logic [PW-1:0] Fre_word, Pha_word;
    logic          busy, done, step_tick;

    int pass_cnt  = 0;
    int total_cnt = 0;

    dds_sweep_ctrl #(.PHASE_WIDTH(PW), .STEP_WIDTH(SW), .DWELL_WIDTH(DW)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start      (start),
        .abort      (abort),
        .hold       (hold),
        .mode_cont  (mode_cont),
        .start_word (start_word),
        .step_word  (step_word),
        .step_num   (step_num),
        .dwell      (dwell),
        .pha_in     (pha_in),
        .Fre_word   (Fre_word),
        .Pha_word   (Pha_word),
        .busy       (busy),
        .done       (done),
        .step_tick  (step_tick)
    );

    always #5 clk_in = ~clk_in;

    // Stimulus helpers (no checking inside).
    task automatic set_cfg(input logic [PW-1:0] sw, input logic [PW-1:0] st,
                           input logic [SW-1:0] n, input logic [DW-1:0] d,
                           input logic mc, input logic [PW-1:0] ph);
        start_word = sw; step_word = st; step_num = n; dwell = d;
        mode_cont = mc; pha_in = ph;
    endtask

    // Pulses start across one edge (E0); returns #1 after E0.
    task automatic start_sweep();
        @(negedge clk_in);
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
    endtask

    task automatic abort_now();
        @(negedge clk_in);
        abort = 1'b1;
        @(posedge clk_in);
        #1;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; start = 0; abort = 0; hold = 0;
        set_cfg(32'd0, 32'd0, 16'd0, 16'd0, 1'b0, 32'd0);
        repeat (3) @(posedge clk_in);
        #1;
        total_cnt++;
        if ({Fre_word, Pha_word, busy, done, step_tick} !== '0)
            $display("FAIL reset_outputs: got fre=%h pha=%h b/d/t=%b%b%b, want all 0",
                     Fre_word, Pha_word, busy, done, step_tick);
        else pass_cnt++;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        total_cnt++;
        if ({busy, step_tick, Fre_word} !== '0)
            $display("FAIL reset_idle: got busy=%b tick=%b fre=%h, want 0 0 0",
                     busy, step_tick, Fre_word);
        else pass_cnt++;
    endtask

    // start 1000, +100, 3 steps, dwell 2, single-shot; inputs scrambled after E0.
    task automatic test_single_shot();
        int busy_n = 0, tick_n = 0, done_n = 0;
        logic [PW-1:0] exp_fre;
        logic [2:0]    exp_bdt;
        set_cfg(32'd1000, 32'd100, 16'd3, 16'd2, 1'b0, 32'h0000_1234);
        start_sweep();
        set_cfg(32'd7, 32'd5, 16'd0, 16'd9, 1'b1, 32'h55);
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) begin @(posedge clk_in); #1; end
            if (k < 12) begin
                exp_fre = PW'(1000 + 100 * (k / 3));
                exp_bdt = {1'b1, 1'b0, (k % 3 == 0)};
            end else begin
                exp_fre = 32'd1300;
                exp_bdt = {1'b0, (k == 12), 1'b0};
            end
            busy_n += int'(busy); tick_n += int'(step_tick); done_n += int'(done);
            total_cnt++;
            if (Fre_word !== exp_fre)
                $display("FAIL single_fre k=%0d: got %0d want %0d", k, Fre_word, exp_fre);
            else pass_cnt++;
            total_cnt++;
            if ({busy, done, step_tick} !== exp_bdt)
                $display("FAIL single_bdt k=%0d: got %b want %b", k, {busy, done, step_tick}, exp_bdt);
            else pass_cnt++;
        end
        total_cnt++;
        if (Pha_word !== 32'h0000_1234)
            $display("FAIL single_pha: got %h want 00001234", Pha_word);
        else pass_cnt++;
        total_cnt++;
        if (busy_n != 12 || tick_n != 4 || done_n != 1)
            $display("FAIL single_counts: got busy=%0d ticks=%0d done=%0d want 12 4 1",
                     busy_n, tick_n, done_n);
        else pass_cnt++;
    endtask

    // Wrap through zero, dwell 0.
    task automatic test_wrap();
        logic [PW-1:0] exp_fre [0:2];
        logic [2:0]    exp_bdt [0:2];
        exp_fre[0] = 32'hFFFF_FFF0; exp_bdt[0] = 3'b101;
        exp_fre[1] = 32'h0000_0010; exp_bdt[1] = 3'b101;
        exp_fre[2] = 32'h0000_0010; exp_bdt[2] = 3'b010;
        set_cfg(32'hFFFF_FFF0, 32'h20, 16'd1, 16'd0, 1'b0, 32'd0);
        start_sweep();
        for (int k = 0; k <= 2; k++) begin
            if (k > 0) begin @(posedge clk_in); #1; end
            total_cnt++;
            if (Fre_word !== exp_fre[k] || {busy, done, step_tick} !== exp_bdt[k])
                $display("FAIL wrap k=%0d: got fre=%h bdt=%b want fre=%h bdt=%b",
                         k, Fre_word, {busy, done, step_tick}, exp_fre[k], exp_bdt[k]);
            else pass_cnt++;
        end
    endtask

    // Start asserted while done is high; step_num 0 holds one word dwell+1 cycles.
    task automatic test_back_to_back();
        logic [2:0] exp_bdt [0:3];
        exp_bdt[0] = 3'b101; exp_bdt[1] = 3'b100; exp_bdt[2] = 3'b010; exp_bdt[3] = 3'b000;
        set_cfg(32'h42, 32'h1, 16'd0, 16'd1, 1'b0, 32'h9);
        start_sweep();
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) begin @(posedge clk_in); #1; end
            total_cnt++;
            if (Fre_word !== 32'h42 || {busy, done, step_tick} !== exp_bdt[k])
                $display("FAIL b2b k=%0d: got fre=%h bdt=%b want fre=00000042 bdt=%b",
                         k, Fre_word, {busy, done, step_tick}, exp_bdt[k]);
            else pass_cnt++;
        end
    endtask

    // Downward continuous sweep 500,400,300,500...
    task automatic test_continuous();
        logic [PW-1:0] exp_fre;
        set_cfg(32'd500, 32'hFFFF_FF9C, 16'd2, 16'd1, 1'b1, 32'd0);
        start_sweep();
        for (int k = 0; k <= 13; k++) begin
            if (k > 0) begin @(posedge clk_in); #1; end
            exp_fre = PW'(500 - 100 * ((k / 2) % 3));
            total_cnt++;
            if (Fre_word !== exp_fre || {busy, done, step_tick} !== {1'b1, 1'b0, (k % 2 == 0)})
                $display("FAIL cont k=%0d: got fre=%0d bdt=%b want fre=%0d bdt=%b",
                         k, Fre_word, {busy, done, step_tick}, exp_fre,
                         {1'b1, 1'b0, (k % 2 == 0)});
            else pass_cnt++;
        end
        abort_now();
    endtask

    // Hold for 5 edges mid-dwell of the single-shot sweep.
    task automatic test_hold();
        int busy_n = 0, kp;
        logic [PW-1:0] exp_fre;
        logic [2:0]    exp_bdt;
        set_cfg(32'd1000, 32'd100, 16'd3, 16'd2, 1'b0, 32'd0);
        start_sweep();
        busy_n += int'(busy);
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk_in);
            hold = (k >= 2 && k <= 6);
            @(posedge clk_in);
            #1;
            kp = (k <= 1) ? k : ((k <= 6) ? 1 : k - 5);
            exp_fre = PW'(1000 + 100 * ((kp / 3 > 3) ? 3 : kp / 3));
            exp_bdt = {(kp < 12), (kp == 12), (kp < 12 && kp % 3 == 0)};
            busy_n += int'(busy);
            total_cnt++;
            if (Fre_word !== exp_fre || {busy, done, step_tick} !== exp_bdt)
                $display("FAIL hold k=%0d: got fre=%0d bdt=%b want fre=%0d bdt=%b",
                         k, Fre_word, {busy, done, step_tick}, exp_fre, exp_bdt);
            else pass_cnt++;
        end
        hold = 1'b0;
        total_cnt++;
        if (busy_n != 17)
            $display("FAIL hold_busy_cycles: got %0d want 17", busy_n);
        else pass_cnt++;
    endtask

    // Abort at edge 7 of the continuous sweep; start pulsed during RUN at edge 3.
    task automatic test_abort();
        logic [PW-1:0] exp_fre;
        logic [2:0]    exp_bdt;
        set_cfg(32'd500, 32'hFFFF_FF9C, 16'd2, 16'd1, 1'b1, 32'hABCD);
        start_sweep();
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_in);
            start = (k == 3);
            abort = (k == 7);
            if (k == 3) start_word = 32'd9999;
            @(posedge clk_in);
            #1;
            if (k <= 6) begin
                exp_fre = PW'(500 - 100 * ((k / 2) % 3));
                exp_bdt = {1'b1, 1'b0, (k % 2 == 0)};
            end else begin
                exp_fre = 32'd500;
                exp_bdt = 3'b000;
            end
            total_cnt++;
            if (Fre_word !== exp_fre || {busy, done, step_tick} !== exp_bdt)
                $display("FAIL abort k=%0d: got fre=%0d bdt=%b want fre=%0d bdt=%b",
                         k, Fre_word, {busy, done, step_tick}, exp_fre, exp_bdt);
            else pass_cnt++;
        end
        start = 1'b0; abort = 1'b0;
        total_cnt++;
        if (Pha_word !== 32'hABCD)
            $display("FAIL abort_pha: got %h want 0000abcd", Pha_word);
        else pass_cnt++;
    endtask

    // Async reset asserted between edges mid-sweep, then a clean restart.
    task automatic test_async_reset();
        set_cfg(32'd1000, 32'd100, 16'd3, 16'd2, 1'b0, 32'h77);
        start_sweep();
        repeat (4) @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        total_cnt++;
        if ({Fre_word, Pha_word, busy, done, step_tick} !== '0)
            $display("FAIL async_reset: got fre=%h pha=%h bdt=%b%b%b want all 0",
                     Fre_word, Pha_word, busy, done, step_tick);
        else pass_cnt++;
        @(negedge clk_in);
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL async_reset_idle: got busy=%b want 0", busy);
        else pass_cnt++;
        start_sweep();
        total_cnt++;
        if (Fre_word !== 32'd1000 || {busy, step_tick} !== 2'b11 || Pha_word !== 32'h77)
            $display("FAIL async_reset_restart: got fre=%0d bt=%b pha=%h want 1000 11 00000077",
                     Fre_word, {busy, step_tick}, Pha_word);
        else pass_cnt++;
        abort_now();
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_wrap();
        test_back_to_back();
        test_continuous();
        test_hold();
        test_abort();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
